inst_ram_loader: RTL and testbench
==================================

INST_RAM_LOADER -- requirements
Module: inst_ram_loader

Interface
REQ-001 Parameter INST_MEM_NUM, default 1024: instruction memory depth in 32-bit words.
REQ-002 Parameter INST_MEM_NUM_LOG2, default 10: word-index width, equal to log2(INST_MEM_NUM).
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ce  input  1  fetch enable from the core.
REQ-006 addr  input  32 (`InstAddrBus)  fetch byte address from the core.
REQ-007 inst  output  32 (`InstBus)  fetched instruction word to the core.
REQ-008 stall_req  output  1  core must hold its PC while high.
REQ-009 ld_valid  input  1  load byte present.
REQ-010 ld_data  input  8  load byte.
REQ-011 ld_last  input  1  current byte is the final byte of the image.
REQ-012 ld_ready  output  1  loader accepts a byte this cycle.
REQ-013 ld_done  output  1  image load complete (sticky until reset).
REQ-014 ld_err  output  1  image overflowed memory (sticky until reset).
REQ-015 ld_words  output  INST_MEM_NUM_LOG2+1  count of words written.

Function
REQ-016 FSM states: LOAD and RUN; reset enters LOAD; LOAD -> RUN on an accepted byte with ld_last=1; RUN persists until rst.
REQ-017 LOAD: ld_ready=1, stall_req=1, inst=`ZeroWord; a byte is accepted only when ld_valid&ld_ready.
REQ-018 Byte assembly big-endian: 1st byte -> inst bits 31:24, 2nd -> 23:16, 3rd -> 15:8, 4th -> 7:0; 2-bit byte counter wraps 3 -> 0.
REQ-019 On the 4th accepted byte, the assembled word is written to mem[wr_ptr] in the same cycle and wr_ptr increments.
REQ-020 ld_last on byte 1-3 of a word: remaining low bytes are zero-padded and the word is written in that same cycle.
REQ-021 Overflow: a completed word with wr_ptr = INST_MEM_NUM is discarded, ld_err is set, wr_ptr saturates; loading continues until ld_last.
REQ-022 ld_words = wr_ptr; increments once per written word and saturates at INST_MEM_NUM.
REQ-023 RUN: ld_ready=0, stall_req=0, ld_done=1; ld_valid and ld_last are ignored.
REQ-024 RUN fetch is combinational: ce=1 and addr[31:INST_MEM_NUM_LOG2+2]=0 -> inst = mem[addr[INST_MEM_NUM_LOG2+1:2]].
REQ-025 RUN: ce=0, or any nonzero upper address bit -> inst=`ZeroWord (nop); addr[1:0] is ignored.
REQ-026 Unloaded locations read as whatever the array holds; reset does not clear memory.

Reset
REQ-027 rst=1 on a rising edge forces: state=LOAD, byte counter=0, wr_ptr=0, assembly register=0, ld_done=0, ld_err=0.
REQ-028 Output values during and after reset: stall_req=1, ld_ready=1, inst=`ZeroWord, ld_words=0.
REQ-029 rst asserted mid-word or in RUN discards any partial word and restarts loading at word 0; no memory write occurs in a reset cycle.

Structure
REQ-030 `InstAddrBus, `InstBus, `ZeroWord, `InstMemNum and `InstMemNumLog2 are defined in defines.v; there are no local literals for these widths.
REQ-031 One sub-module, inst_ram: single synchronous write port plus one combinational read port, with depth taken from the parameters.
REQ-032 FSM, byte assembler, counters and output muxing reside in inst_ram_loader.

Verification
REQ-033 Reset, then 8 bytes 24 01 00 05 34 02 00 07 (last on 8th) -> ld_words=2, ld_done=1, stall_req=0; ce=1, addr=0x4 -> inst=0x34020007.
REQ-034 6 bytes 3C 01 12 34 AB CD (last on 6th) -> word1=0xABCD0000, ld_words=2; addr=0x0 -> 0x3C011234.
REQ-035 ld_valid toggled 1/0 every cycle while loading 4 bytes -> exactly one write; byte order is preserved.
REQ-036 INST_MEM_NUM=4, load 5 words -> ld_err=1, ld_words=4, mem[3] holds the 4th word.
REQ-037 RUN with ce=0 -> inst=0; addr=0x1000 (depth 1024) -> inst=0; addr=0x7 -> returns word 1.
REQ-038 rst after 2 bytes of a word, then a fresh 4-byte image -> mem[0] holds only the new word, ld_words=1.

Source files
------------

// File: rtl/inst_ram_loader_pkg.sv
// +------------------------------------------------------------------+
// | inst_ram_loader_pkg : shared bus types, widths and loader states |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

`ifndef INST_RAM_LOADER_DEFINES
`define INST_RAM_LOADER_DEFINES
`define InstAddrBus    31:0
`define InstBus        31:0
`define ZeroWord       32'h00000000
`define InstMemNum     1024
`define InstMemNumLog2 10
`endif

package inst_ram_loader_pkg;

  typedef logic [`InstAddrBus] addr_t;
  typedef logic [`InstBus]     inst_t;
  typedef logic [7:0]          byte_t;

  localparam int    INST_ADDR_W      = $bits(addr_t);
  localparam inst_t ZERO_WORD        = `ZeroWord;
  localparam int    DEF_MEM_NUM      = `InstMemNum;
  localparam int    DEF_MEM_NUM_LOG2 = `InstMemNumLog2;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Big-endian placement: byte index 0 lands in the most significant lane.
  function automatic inst_t place_byte(input inst_t acc, input byte_t b,
                                       input logic [1:0] idx);
    inst_t r;
    r = acc;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_ram_loader_if.sv
// +------------------------------------------------------------------+
// | inst_ram_loader_if : core fetch port plus byte-stream load port  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

import inst_ram_loader_pkg::*;

interface inst_ram_loader_if #(
  parameter int INST_MEM_NUM_LOG2 = DEF_MEM_NUM_LOG2
);
  logic                       ce;
  addr_t                      addr;
  inst_t                      inst;
  logic                       stall_req;
  logic                       ld_valid;
  byte_t                      ld_data;
  logic                       ld_last;
  logic                       ld_ready;
  logic                       ld_done;
  logic                       ld_err;
  logic [INST_MEM_NUM_LOG2:0] ld_words;

  modport master (
    output ce, addr, ld_valid, ld_data, ld_last,
    input  inst, stall_req, ld_ready, ld_done, ld_err, ld_words
  );

  modport slave (
    input  ce, addr, ld_valid, ld_data, ld_last,
    output inst, stall_req, ld_ready, ld_done, ld_err, ld_words
  );
endinterface

`default_nettype wire

// File: rtl/inst_ram_loader_inst_ram.sv
// +------------------------------------------------------------------+
// | inst_ram : one synchronous write port, one combinational read    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

import inst_ram_loader_pkg::*;

module inst_ram #(
  parameter int INST_MEM_NUM      = DEF_MEM_NUM,
  parameter int INST_MEM_NUM_LOG2 = DEF_MEM_NUM_LOG2
) (
  input  wire logic                         clk,
  input  wire logic                         we,
  input  wire logic [INST_MEM_NUM_LOG2-1:0] waddr,
  input  wire inst_t                        wdata,
  input  wire logic [INST_MEM_NUM_LOG2-1:0] raddr,
  output inst_t                             rdata
);
  inst_t mem [INST_MEM_NUM];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

`default_nettype wire

// File: rtl/inst_ram_loader.sv
// +------------------------------------------------------------------+
// | inst_ram_loader : boots instruction RAM from a byte stream, then |
// | serves combinational fetches. Rev 1.0                            |
// +------------------------------------------------------------------+
`default_nettype none

import inst_ram_loader_pkg::*;

module inst_ram_loader #(
  parameter int INST_MEM_NUM      = DEF_MEM_NUM,
  parameter int INST_MEM_NUM_LOG2 = DEF_MEM_NUM_LOG2
) (
  input wire logic          clk,
  input wire logic          rst,
  inst_ram_loader_if.slave  bus
);
  localparam logic [INST_MEM_NUM_LOG2:0] c_mem_num = INST_MEM_NUM[INST_MEM_NUM_LOG2:0];
  localparam logic [INST_MEM_NUM_LOG2:0] c_ptr_one = 1;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [1:0]                 r_byte_cnt;
  logic [INST_MEM_NUM_LOG2:0] r_wr_ptr;
  inst_t                      r_asm;
  logic                       r_done;
  logic                       r_err;

  inst_t w_word;
  inst_t w_rdata;
  inst_t w_inst;
  logic  w_accept;
  logic  w_word_end;
  logic  w_room;
  logic  w_we;
  logic  w_addr_ok;
  logic  w_ready;
  logic  w_stall;
  logic  w_unused;

  // Nothing is accepted (hence nothing written) while reset is asserted.
  assign w_accept   = (r_state == ST_LOAD) && bus.ld_valid && !rst;
  assign w_word     = place_byte(r_asm, bus.ld_data, r_byte_cnt);
  assign w_word_end = w_accept && ((r_byte_cnt == 2'd3) || bus.ld_last);
  assign w_room     = (r_wr_ptr < c_mem_num);
  assign w_we       = w_word_end && w_room;
  assign w_addr_ok  = (bus.addr[INST_ADDR_W-1:INST_MEM_NUM_LOG2+2] == '0);
  assign w_unused   = ^bus.addr[1:0];

  inst_ram #(
    .INST_MEM_NUM      (INST_MEM_NUM),
    .INST_MEM_NUM_LOG2 (INST_MEM_NUM_LOG2)
  ) u_inst_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_ptr[INST_MEM_NUM_LOG2-1:0]),
    .wdata (w_word),
    .raddr (bus.addr[INST_MEM_NUM_LOG2+1:2]),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_stall     = 1'b0;
    w_inst      = ZERO_WORD;
    case (r_state)
      ST_LOAD: begin
        w_ready = 1'b1;
        w_stall = 1'b1;
        if (w_accept && bus.ld_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.ce && w_addr_ok) begin
          w_inst = w_rdata;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
    if (rst) begin
      w_ready = 1'b1;
      w_stall = 1'b1;
      w_inst  = ZERO_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= 2'd0;
      r_wr_ptr   <= '0;
      r_asm      <= ZERO_WORD;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      if (w_word_end) begin
        r_asm      <= ZERO_WORD;
        r_byte_cnt <= 2'd0;
        if (w_room) begin
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end else begin
          r_err    <= 1'b1;
        end
      end else begin
        r_asm      <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (bus.ld_last) begin
        r_done <= 1'b1;
      end
    end
  end

  assign bus.inst      = w_inst;
  assign bus.stall_req = w_stall;
  assign bus.ld_ready  = w_ready;
  assign bus.ld_done   = r_done;
  assign bus.ld_err    = r_err;
  assign bus.ld_words  = rst ? '0 : r_wr_ptr;
endmodule

`default_nettype wire

// File: tb/tb_inst_ram_loader.sv
// +------------------------------------------------------------------+
// | tb_inst_ram_loader : directed and random image loads vs a model  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

import inst_ram_loader_pkg::*;

module tb_inst_ram_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_ram_loader_if #(.INST_MEM_NUM_LOG2(10)) bus0 ();
  inst_ram_loader_if #(.INST_MEM_NUM_LOG2(2))  bus4 ();

  inst_ram_loader #(.INST_MEM_NUM(1024), .INST_MEM_NUM_LOG2(10)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  inst_ram_loader #(.INST_MEM_NUM(4), .INST_MEM_NUM_LOG2(2)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  int    checks = 0;
  int    errors = 0;
  byte_t img[$];

  logic [31:0] s_inst, s_words;
  logic        s_stall, s_ready, s_done, s_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input byte_t d, input logic l,
                       input logic c, input logic [31:0] a);
    if (sel == 0) begin
      bus0.ld_valid = v; bus0.ld_data = d; bus0.ld_last = l; bus0.ce = c; bus0.addr = a;
      bus4.ld_valid = 1'b0; bus4.ld_last = 1'b0;
    end else begin
      bus4.ld_valid = v; bus4.ld_data = d; bus4.ld_last = l; bus4.ce = c; bus4.addr = a;
      bus0.ld_valid = 1'b0; bus0.ld_last = 1'b0;
    end
  endtask

  task automatic sample(input int sel);
    if (sel == 0) begin
      s_inst = bus0.inst; s_stall = bus0.stall_req; s_ready = bus0.ld_ready;
      s_done = bus0.ld_done; s_err = bus0.ld_err; s_words = 32'(bus0.ld_words);
    end else begin
      s_inst = bus4.inst; s_stall = bus4.stall_req; s_ready = bus4.ld_ready;
      s_done = bus4.ld_done; s_err = bus4.ld_err; s_words = 32'(bus4.ld_words);
    end
  endtask

  task automatic do_reset(input int sel);
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    sample(sel);
    check("rst_stall", 32'(s_stall), 32'd1);
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_inst",  s_inst,       32'h0);
    check("rst_words", s_words,      32'd0);
    check("rst_done",  32'(s_done),  32'd0);
    check("rst_err",   32'(s_err),   32'd0);
    rst = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps
  task automatic load(input int sel, input int mode, input bit use_last);
    for (int i = 0; i < img.size(); i++) begin
      int gap;
      gap = (mode == 0) ? 0 : (mode == 1) ? ((i > 0) ? 1 : 0) : int'($urandom_range(0, 2));
      repeat (gap) begin
        @(posedge clk); #1;
      end
      drive(sel, 1'b1, img[i], use_last && (i == img.size() - 1), 1'b0, 32'h0);
      @(posedge clk); #1;
      drive(sel, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    end
  endtask

  task automatic rd(input int sel, input logic c, input logic [31:0] a);
    drive(sel, 1'b0, 8'h00, 1'b0, c, a);
    @(negedge clk);
    sample(sel);
  endtask

  // Reference: pack the byte image into zero-padded big-endian words.
  function automatic logic [31:0] model_word(input int w);
    logic [31:0] r;
    r = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (4 * w + k < img.size()) r[31 - 8 * k -: 8] = img[4 * w + k];
    end
    return r;
  endfunction

  task automatic check_image(input int sel, input int depth, input int log2);
    int nw, kept;
    nw   = (img.size() + 3) / 4;
    kept = (nw > depth) ? depth : nw;
    @(negedge clk);
    sample(sel);
    check("img_words", s_words,      32'(kept));
    check("img_err",   32'(s_err),   32'(nw > depth));
    check("img_done",  32'(s_done),  32'd1);
    check("img_stall", 32'(s_stall), 32'd0);
    check("img_ready", 32'(s_ready), 32'd0);
    for (int w = 0; w < kept; w++) begin
      rd(sel, 1'b1, 32'(4 * w) + 32'($urandom_range(0, 3)));
      check("img_read", s_inst, model_word(w));
    end
    rd(sel, 1'b0, 32'h0);
    check("img_ce0", s_inst, 32'h0);
    rd(sel, 1'b1, (32'h1 << $urandom_range(log2 + 2, 31)) | 32'($urandom_range(0, 3)));
    check("img_oob", s_inst, 32'h0);
  endtask

  initial begin
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    do_reset(0);
    img = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h34, 8'h02, 8'h00, 8'h07};
    load(0, 0, 1'b1);
    check_image(0, 1024, 10);
    rd(0, 1'b1, 32'h4);      check("dir_addr4", s_inst, 32'h34020007);
    rd(0, 1'b0, 32'h4);      check("run_ce0",   s_inst, 32'h0);
    rd(0, 1'b1, 32'h1000);   check("run_oob",   s_inst, 32'h0);
    rd(0, 1'b1, 32'h7);      check("run_addr7", s_inst, 32'h34020007);
    // Stream bytes after RUN must be ignored.
    drive(0, 1'b1, 8'hFF, 1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    sample(0);
    check("run_ignore_words", s_words, 32'd2);
    check("run_ignore_inst",  s_inst,  32'h24010005);

    do_reset(0);
    img = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD};
    load(0, 0, 1'b1);
    check_image(0, 1024, 10);
    rd(0, 1'b1, 32'h0);      check("pad_w0", s_inst, 32'h3C011234);
    rd(0, 1'b1, 32'h4);      check("pad_w1", s_inst, 32'hABCD0000);

    do_reset(0);
    img.delete();
    repeat (4) img.push_back(byte_t'($urandom_range(0, 255)));
    load(0, 1, 1'b1);
    check_image(0, 1024, 10);

    do_reset(0);
    img = '{8'hDE, 8'hAD};
    load(0, 0, 1'b0);
    do_reset(0);
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    load(0, 0, 1'b1);
    check_image(0, 1024, 10);
    rd(0, 1'b1, 32'h0);      check("rst_mid_w0", s_inst, 32'h11223344);

    for (int it = 0; it < 6; it++) begin
      do_reset(0);
      img.delete();
      repeat ($urandom_range(1, 40)) img.push_back(byte_t'($urandom_range(0, 255)));
      load(0, 2, 1'b1);
      check_image(0, 1024, 10);
    end

    do_reset(1);
    img.delete();
    repeat (20) img.push_back(byte_t'($urandom_range(0, 255)));
    load(1, 0, 1'b1);
    check_image(1, 4, 2);
    rd(1, 1'b1, 32'hC);      check("ovf_mem3", s_inst, model_word(3));

    for (int it = 0; it < 3; it++) begin
      do_reset(1);
      img.delete();
      repeat ($urandom_range(1, 26)) img.push_back(byte_t'($urandom_range(0, 255)));
      load(1, 2, 1'b1);
      check_image(1, 4, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
